pipe_exec_stage: RTL
====================

PIPE_EXEC_STAGE -- requirements
Module: pipe_exec_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LANES  4  vector lanes per operand
  LANE_W  32  bits per lane
  REG_AW  4  register-index width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous reset, active-low
  flush  in  1  kill all in-flight entries (taken jump)
  in_valid  in  1  upstream entry valid
  in_ready  out  1  stage can accept an entry
  in_ctrl  in  ctrl_t  decoded control bundle
  in_ra  in  LANES*LANE_W  operand A
  in_rb  in  LANES*LANE_W  operand B
  in_rs1  in  REG_AW  source index 1
  in_rs2  in  REG_AW  source index 2
  in_rd  in  REG_AW  destination index
  out_valid  out  1  downstream entry valid
  out_ready  in  1  downstream accepts entry
  out_ctrl, out_ra, out_rb, out_rs1, out_rs2, out_rd  out  as inputs  registered entry
REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 Storage SHALL be a two-entry skid buffer: main register (drives outputs) and skid register.
REQ-005 Transfers SHALL occur only on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-006 in_ready SHALL be registered and equal !skid_valid; no combinational path from out_ready to in_ready.
REQ-007 Input-to-output latency SHALL be 1 cycle when main is empty or draining.
REQ-008 If main is empty or draining, main SHALL load from skid when skid_valid, otherwise from input; an accepted input then goes to skid if skid held data.
REQ-009 If main is full and not draining, an accepted input SHALL go to skid and in_ready SHALL drop next cycle.
REQ-010 Entry order SHALL be preserved; no entry dropped or duplicated absent flush.
REQ-011 While out_valid=0, out_ctrl SHALL be all-zero (no write/jump/mem enables); data fields may hold stale values.
REQ-012 Asserted flush SHALL clear main_valid and skid_valid next cycle, discard any input offered that cycle, zero out_ctrl, and set in_ready=1.
REQ-013 Flush with full skid plus a stalled output SHALL still clear both entries in one cycle.
REQ-014 Outputs SHALL hold stable while out_valid&&!out_ready.

Reset
REQ-015 With rst=0 at a clk edge, all outputs SHALL be zero except in_ready=1; both valid flags SHALL clear.
REQ-016 Reset SHALL take priority over flush and over any handshake in the same cycle.
REQ-017 Reset mid-stall SHALL discard both entries; the first post-reset accept SHALL appear with latency 1.

Configuration
REQ-018 With PIPE_EXEC_PERF_EN defined, 32-bit outputs bubble_cnt (cycles with out_valid=0) and stall_cnt (cycles with out_valid&&!out_ready) SHALL exist, saturate at 32'hFFFFFFFF, and clear on reset.
REQ-019 Without PIPE_EXEC_PERF_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-020 Package pipe_pkg SHALL hold ctrl_t (packed: wmem, rmem, wreg, wpc, cond_en, imm_f, jmp[1:0], alu_ins[2:0], extnd_sel[1:0]), CTRL_ZERO, and default LANES/LANE_W/REG_AW constants.
REQ-021 Entry payload SHALL be one packed struct entry_t in pipe_pkg; main and skid registers SHALL be of that type.
REQ-022 No sub-module; the skid buffer is inline.

Verification
REQ-023 Reset: rst=0 two cycles, inputs random -> out_valid=0, out_ctrl=0, in_ready=1, counters 0.
REQ-024 Streaming: out_ready=1, 8 back-to-back entries with in_rd=1..8 -> out_rd 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
REQ-025 Backpressure: out_ready=0 after entry A, offer B, C -> B to skid, in_ready=0 next cycle, C held upstream; out_ready=1 -> A, B, C out in order.
REQ-026 Flush: main and skid full, out_ready=0, flush=1 with D offered -> next cycle out_valid=0, out_ctrl=0, in_ready=1, D never appears.
REQ-027 Priority: rst=0 and flush=1 with in_valid=1 same cycle -> reset values; next accepted entry E appears 1 cycle later.
REQ-028 Perf (PIPE_EXEC_PERF_EN): 5 idle cycles then 3 stalled cycles -> bubble_cnt=5, stall_cnt=3; preload near-max -> saturates at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the execute-stage pipeline register.
// Optional perf counters are enabled by defining PIPE_EXEC_PERF_EN.
package pipe_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 32;
    localparam int DEF_REG_AW = 4;
    localparam int DATA_W     = DEF_LANES * DEF_LANE_W;

    typedef struct packed {
        logic       wmem;
        logic       rmem;
        logic       wreg;
        logic       wpc;
        logic       cond_en;
        logic       imm_f;
        logic [1:0] jmp;
        logic [2:0] alu_ins;
        logic [1:0] extnd_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    typedef struct packed {
        ctrl_t                  ctrl;
        logic [DATA_W-1:0]      ra;
        logic [DATA_W-1:0]      rb;
        logic [DEF_REG_AW-1:0]  rs1;
        logic [DEF_REG_AW-1:0]  rs2;
        logic [DEF_REG_AW-1:0]  rd;
    } entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_exec_stage.sv
// Execute-stage pipeline register: two-entry skid buffer, flush on jump.
// Define PIPE_EXEC_PERF_EN to add saturating bubble/stall counters.
module pipe_exec_stage
    import pipe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  ctrl_t                   in_ctrl,
    input  logic [LANES*LANE_W-1:0] in_ra,
    input  logic [LANES*LANE_W-1:0] in_rb,
    input  logic [REG_AW-1:0]       in_rs1,
    input  logic [REG_AW-1:0]       in_rs2,
    input  logic [REG_AW-1:0]       in_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output ctrl_t                   out_ctrl,
    output logic [LANES*LANE_W-1:0] out_ra,
    output logic [LANES*LANE_W-1:0] out_rb,
    output logic [REG_AW-1:0]       out_rs1,
    output logic [REG_AW-1:0]       out_rs2,
    output logic [REG_AW-1:0]       out_rd
`ifdef PIPE_EXEC_PERF_EN
    ,
    output logic [31:0]             bubble_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t in_entry;
    logic   drain;
    logic   in_fire;

    always_comb begin
        in_entry      = '0;
        in_entry.ctrl = in_ctrl;
        in_entry.ra   = in_ra;
        in_entry.rb   = in_rb;
        in_entry.rs1  = in_rs1;
        in_entry.rs2  = in_rs2;
        in_entry.rd   = in_rd;
    end

    // in_ready comes straight from a flop, so out_ready never reaches it.
    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && !skid_valid_q;
    assign drain    = !main_valid_q || out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
                if (in_fire) begin
                    skid_d       = in_entry;
                    skid_valid_d = 1'b1;
                end
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d = in_entry;
                end
            end
        end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Control is gated so a bubble can never fire a write, jump or memory op.
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_valid_q ? main_q.ctrl : CTRL_ZERO;
    assign out_ra    = main_q.ra;
    assign out_rb    = main_q.rb;
    assign out_rs1   = main_q.rs1;
    assign out_rs2   = main_q.rs2;
    assign out_rd    = main_q.rd;

`ifdef PIPE_EXEC_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!main_valid_q) begin
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (!out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
